audio_pwm_dac: RTL and testbench

Parametrised next-generation audio output block. It receives a left-justified serial audio stream (32-bit slots, channel data MSB-first), selects or mixes the channels, and applies signed volume scaling with saturation. It renders the result as a single-pin PWM with configurable resolution, and includes an idle-mute timeout and a tone-generator mode. It sits between the codec-style serial audio source and the speaker driver pin, and is configured through the standard 4-bit-address register bus.

---
 rtl/audio_dac_pkg.sv | 29 ++
 rtl/lj_serial_rx.sv | 75 +++++++
 rtl/audio_pwm_dac.sv | 214 +++++++++++++++++++++
 tb/tb_audio_pwm_dac.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_dac_pkg.sv
// Shared types and register map for the audio PWM DAC.
package audio_dac_pkg;

  // Output mode; encoding 3 is also treated as off
  typedef enum logic [1:0] {
    MODE_OFF  = 2'd0,
    MODE_TONE = 2'd1,
    MODE_WAVE = 2'd2
  } modeT;

  // Channel selection; encoding 3 is also treated as mix
  typedef enum logic [1:0] {
    CH_MIX   = 2'd0,
    CH_LEFT  = 2'd1,
    CH_RIGHT = 2'd2
  } chSelT;

  // Register addresses
  localparam logic [3:0] ADDR_CTRL   = 4'd0;
  localparam logic [3:0] ADDR_VOLUME = 4'd1;
  localparam logic [3:0] ADDR_FREQ   = 4'd2;
  localparam logic [3:0] ADDR_STATUS = 4'd3;

  // Ctrl register field positions
  localparam int CTRL_MODE_LSB  = 0;
  localparam int CTRL_CHSEL_LSB = 2;
  localparam int CTRL_UNSIGNED  = 4;

endpackage

// File: rtl/lj_serial_rx.sv
// Left-justified serial audio receiver: brings the bit clock, frame sync and
// data into the Clk domain, shifts each slot MSB-first and latches the
// completed samples on frame-sync edges.
module lj_serial_rx #(
  parameter int SAMPLE_W = 16
) (
  input  logic                Clk,
  input  logic                Resetn,
  input  logic                AbitClk,
  input  logic                Async,
  input  logic                Asdo,
  output logic [SAMPLE_W-1:0] LeftSample,
  output logic [SAMPLE_W-1:0] RightSample,
  output logic [7:0]          FrameCnt
);

  localparam int CNT_W = $clog2(SAMPLE_W + 1);

  // Stages [1:0] are the synchroniser, stage [2] is the edge-detect history
  logic [2:0] bclkSync;
  logic [2:0] lrSync;
  logic [1:0] dataSync;

  logic [SAMPLE_W-1:0] leftShift;
  logic [SAMPLE_W-1:0] rightShift;
  logic [CNT_W-1:0]    bitCnt;

  logic bclkRise;
  logic lrRise;
  logic lrFall;

  assign bclkRise = bclkSync[1] & ~bclkSync[2];
  assign lrRise   = lrSync[1] & ~lrSync[2];
  assign lrFall   = ~lrSync[1] & lrSync[2];

  // Two-flop synchronisers for the asynchronous serial inputs
  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      bclkSync <= '0;
      lrSync   <= '0;
      dataSync <= '0;
    end else begin
      bclkSync <= {bclkSync[1:0], AbitClk};
      lrSync   <= {lrSync[1:0], Async};
      dataSync <= {dataSync[0], Asdo};
    end
  end

  // Frame edges latch finished slots and restart the bit count; they win over a coincident bit
  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      leftShift   <= '0;
      rightShift  <= '0;
      bitCnt      <= '0;
      LeftSample  <= '0;
      RightSample <= '0;
      FrameCnt    <= '0;
    end else if (lrRise) begin
      RightSample <= rightShift;
      bitCnt      <= '0;
      FrameCnt    <= FrameCnt + 8'd1;
    end else if (lrFall) begin
      LeftSample <= leftShift;
      bitCnt     <= '0;
    end else if (bclkRise && (bitCnt < CNT_W'(SAMPLE_W))) begin
      if (lrSync[1]) begin
        rightShift <= {rightShift[SAMPLE_W-2:0], dataSync[1]};
      end else begin
        leftShift <= {leftShift[SAMPLE_W-2:0], dataSync[1]};
      end
      bitCnt <= bitCnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/audio_pwm_dac.sv
// Audio PWM DAC: receives left-justified serial audio, selects or mixes the
// channels, applies saturating volume, and drives one speaker pin with PWM
// or a gated square-wave tone. Includes an idle mute on unchanging audio.
module audio_pwm_dac
  import audio_dac_pkg::*;
#(
  parameter int SAMPLE_W   = 16,
  parameter int PWM_W      = 10,
  parameter int VOL_W      = 8,
  parameter int TIMEOUT_W  = 12,
  parameter int TONE_SHIFT = 5
) (
  input  logic        Clk,
  input  logic        Resetn,
  input  logic        AbitClk,
  input  logic        Async,
  input  logic        Asdo,
  output logic        Asdi,
  output logic        Out,
  output logic        SpkEn,
  input  logic [3:0]  Addr,
  input  logic [15:0] DataWr,
  output logic [15:0] DataRd,
  input  logic        En,
  input  logic        Wr,
  input  logic        Rd
);

  localparam int PROD_W = SAMPLE_W + VOL_W + 2;
  localparam int ACC_W  = TONE_SHIFT + 16;

  // Configuration registers
  modeT             mode;
  chSelT            chSel;
  logic             unsignedMode;
  logic [VOL_W-1:0] volume;
  logic [15:0]      freq;

  // Receiver outputs
  logic [SAMPLE_W-1:0] leftSample;
  logic [SAMPLE_W-1:0] rightSample;
  logic [7:0]          frameCnt;

  // Sample path
  logic signed [SAMPLE_W-1:0] leftS;
  logic signed [SAMPLE_W-1:0] rightS;
  logic signed [SAMPLE_W:0]   sum;
  logic signed [SAMPLE_W:0]   mix;
  logic signed [SAMPLE_W:0]   sel;
  logic signed [PROD_W-1:0]   selExt;
  logic signed [PROD_W-1:0]   volExt;
  logic signed [PROD_W-1:0]   prod;
  logic signed [PROD_W-1:0]   scaled;
  logic [SAMPLE_W-1:0]        sat;
  logic [PWM_W-1:0]           newDuty;

  // PWM, idle mute and tone state
  logic [PWM_W-1:0]     divCount;
  logic [PWM_W-1:0]     duty;
  logic [TIMEOUT_W-1:0] idleCnt;
  logic                 muted;
  logic [ACC_W-1:0]     toneAcc;
  logic                 toneSq;
  logic [7:0]           volCnt;
  logic                 volPwm;

  logic unusedBits;
  assign unusedBits = ^{Rd, sat[SAMPLE_W-PWM_W-1:0]};

  assign Asdi  = 1'b0;
  assign muted = (idleCnt == '1);

  lj_serial_rx #(
    .SAMPLE_W(SAMPLE_W)
  ) uRx (
    .Clk        (Clk),
    .Resetn     (Resetn),
    .AbitClk    (AbitClk),
    .Async      (Async),
    .Asdo       (Asdo),
    .LeftSample (leftSample),
    .RightSample(rightSample),
    .FrameCnt   (frameCnt)
  );

  // Register bus writes
  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      mode         <= MODE_WAVE;
      chSel        <= CH_MIX;
      unsignedMode <= 1'b0;
      volume       <= {1'b1, {(VOL_W-1){1'b0}}};
      freq         <= '0;
    end else if (En && Wr) begin
      case (Addr)
        ADDR_CTRL: begin
          mode         <= modeT'(DataWr[CTRL_MODE_LSB +: 2]);
          chSel        <= chSelT'(DataWr[CTRL_CHSEL_LSB +: 2]);
          unsignedMode <= DataWr[CTRL_UNSIGNED];
        end
        ADDR_VOLUME: volume <= DataWr[VOL_W-1:0];
        ADDR_FREQ:   freq   <= DataWr;
        default: ;
      endcase
    end
  end

  // Register readback, purely a function of Addr
  always_comb begin
    DataRd = '0;
    case (Addr)
      ADDR_CTRL: begin
        DataRd[CTRL_MODE_LSB +: 2]  = mode;
        DataRd[CTRL_CHSEL_LSB +: 2] = chSel;
        DataRd[CTRL_UNSIGNED]       = unsignedMode;
      end
      ADDR_VOLUME: DataRd[VOL_W-1:0] = volume;
      ADDR_FREQ:   DataRd = freq;
      ADDR_STATUS: begin
        DataRd[0]    = muted;
        DataRd[15:8] = frameCnt;
      end
      default: ;
    endcase
  end

  // Offset-binary samples become two's complement by flipping the MSB
  assign leftS  = {leftSample[SAMPLE_W-1] ^ unsignedMode, leftSample[SAMPLE_W-2:0]};
  assign rightS = {rightSample[SAMPLE_W-1] ^ unsignedMode, rightSample[SAMPLE_W-2:0]};
  assign sum    = {leftS[SAMPLE_W-1], leftS} + {rightS[SAMPLE_W-1], rightS};
  assign mix    = sum >>> 1;

  // Channel select, volume scaling and saturation to the sample width
  always_comb begin
    sel = mix;
    case (chSel)
      CH_LEFT:  sel = {leftS[SAMPLE_W-1], leftS};
      CH_RIGHT: sel = {rightS[SAMPLE_W-1], rightS};
      default:  sel = mix;
    endcase
    selExt = {{(PROD_W-SAMPLE_W-1){sel[SAMPLE_W]}}, sel};
    volExt = {{(PROD_W-VOL_W){1'b0}}, volume};
    prod   = selExt * volExt;
    scaled = prod >>> (VOL_W - 1);
    if ((scaled[PROD_W-1:SAMPLE_W-1] == '0) || (scaled[PROD_W-1:SAMPLE_W-1] == '1)) begin
      sat = scaled[SAMPLE_W-1:0];
    end else if (scaled[PROD_W-1]) begin
      sat = {1'b1, {(SAMPLE_W-1){1'b0}}};
    end else begin
      sat = {1'b0, {(SAMPLE_W-1){1'b1}}};
    end
    newDuty = {~sat[SAMPLE_W-1], sat[SAMPLE_W-2 -: PWM_W-1]};
  end

  // PWM period counter; duty and idle count update only at the period boundary
  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      divCount <= '0;
      duty     <= {1'b1, {(PWM_W-1){1'b0}}};
      idleCnt  <= '0;
    end else begin
      divCount <= divCount + PWM_W'(1);
      if (divCount == '1) begin
        duty <= newDuty;
        if (newDuty == duty) begin
          if (idleCnt != '1) begin
            idleCnt <= idleCnt + TIMEOUT_W'(1);
          end
        end else begin
          idleCnt <= '0;
        end
      end
    end
  end

  // Tone square wave plus an 8-bit PWM that sets the tone loudness
  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      toneAcc <= '0;
      toneSq  <= 1'b0;
      volCnt  <= '0;
      volPwm  <= 1'b0;
    end else begin
      if (toneAcc[TONE_SHIFT+15:TONE_SHIFT] == freq) begin
        toneSq  <= ~toneSq;
        toneAcc <= '0;
      end else begin
        toneAcc <= toneAcc + ACC_W'(1);
      end
      volCnt <= volCnt + 8'd1;
      if (volCnt == volume[VOL_W-1 -: 8]) begin
        volPwm <= 1'b0;
      end else if (volCnt == 8'd0) begin
        volPwm <= 1'b1;
      end
    end
  end

  // Registered pin drive and speaker enable
  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      Out   <= 1'b0;
      SpkEn <= 1'b1;
    end else begin
      case (mode)
        MODE_TONE: Out <= toneSq & volPwm;
        MODE_WAVE: Out <= (divCount < duty) & ~muted;
        default:   Out <= 1'b0;
      endcase
      SpkEn <= (mode != MODE_OFF);
    end
  end

endmodule

// File: tb/tb_audio_pwm_dac.sv
// Directed testbench for audio_pwm_dac: streams left-justified frames,
// measures PWM high time per period and checks registers, mute and tone.
module tb_audio_pwm_dac;
  import audio_dac_pkg::*;

  logic        Clk = 1'b0;
  logic        Resetn = 1'b0;
  logic        AbitClk = 1'b0;
  logic        Async = 1'b0;
  logic        Asdo = 1'b0;
  logic [3:0]  Addr = 4'd0;
  logic [15:0] DataWr = 16'd0;
  logic        En = 1'b0;
  logic        Wr = 1'b0;
  logic        Rd = 1'b0;
  logic        Asdi;
  logic        Out;
  logic        SpkEn;
  logic [15:0] DataRd;

  logic [15:0] txL = 16'd0;
  logic [15:0] txR = 16'd0;

  int checkCount = 0;
  int errCount = 0;

  // Tone reference state, tracked from the bus and reset like the block
  logic [20:0] mPh;
  logic        mSq;
  logic [7:0]  mCnt;
  logic        mPwm;
  logic        mOut;
  logic [15:0] mFreq;
  logic [7:0]  mVol;
  logic [1:0]  mMode;

  audio_pwm_dac #(
    .SAMPLE_W  (16),
    .PWM_W     (10),
    .VOL_W     (8),
    .TIMEOUT_W (4),
    .TONE_SHIFT(5)
  ) dut (
    .Clk    (Clk),
    .Resetn (Resetn),
    .AbitClk(AbitClk),
    .Async  (Async),
    .Asdo   (Asdo),
    .Asdi   (Asdi),
    .Out    (Out),
    .SpkEn  (SpkEn),
    .Addr   (Addr),
    .DataWr (DataWr),
    .DataRd (DataRd),
    .En     (En),
    .Wr     (Wr),
    .Rd     (Rd)
  );

  always #5 Clk = ~Clk;

  // Serial source: 8 Clk per bit, 32-bit slots, left slot with Async low
  initial begin
    logic [15:0] w;
    forever begin
      for (int slot = 0; slot < 2; slot++) begin
        w = (slot == 1) ? txR : txL;
        for (int b = 0; b < 32; b++) begin
          @(negedge Clk);
          Async   = (slot == 1);
          Asdo    = (b < 16) ? w[15-b] : 1'b0;
          AbitClk = 1'b0;
          repeat (3) @(negedge Clk);
          AbitClk = 1'b1;
          repeat (4) @(negedge Clk);
        end
      end
    end
  end

  // Tone reference: half-period Freq*32+1 cycles, gated by an 8-bit loudness PWM
  always @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      mPh   <= '0;
      mSq   <= 1'b0;
      mCnt  <= '0;
      mPwm  <= 1'b0;
      mOut  <= 1'b0;
      mFreq <= 16'd0;
      mVol  <= 8'h80;
      mMode <= 2'd2;
    end else begin
      if (En && Wr) begin
        if (Addr == ADDR_CTRL) mMode <= DataWr[1:0];
        if (Addr == ADDR_VOLUME) mVol <= DataWr[7:0];
        if (Addr == ADDR_FREQ) mFreq <= DataWr;
      end
      if (mPh == {mFreq, 5'b00000}) begin
        mSq <= ~mSq;
        mPh <= '0;
      end else begin
        mPh <= mPh + 21'd1;
      end
      mCnt <= mCnt + 8'd1;
      if (mCnt == mVol) mPwm <= 1'b0;
      else if (mCnt == 8'd0) mPwm <= 1'b1;
      mOut <= (mMode == 2'd1) ? (mSq & mPwm) : 1'b0;
    end
  end

  initial begin
    #1500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] a, input logic [15:0] d);
    @(negedge Clk);
    Addr = a; DataWr = d; En = 1'b1; Wr = 1'b1;
    @(negedge Clk);
    En = 1'b0; Wr = 1'b0;
  endtask

  task automatic readReg(input logic [3:0] a, output logic [15:0] d);
    Addr = a; En = 1'b1; Rd = 1'b1;
    #1;
    d = DataRd;
    En = 1'b0; Rd = 1'b0;
  endtask

  task automatic settle(input int periods);
    repeat (periods * 1024) @(negedge Clk);
  endtask

  task automatic countHigh(output int n);
    n = 0;
    repeat (1024) begin
      @(negedge Clk);
      if (Out) n++;
    end
  endtask

  initial begin
    logic [15:0] rd;
    logic [15:0] statA;
    logic [15:0] statB;
    int hi;
    int errs;
    int waited;

    repeat (5) @(negedge Clk);
    checkOutput("rstOut", {31'd0, Out}, 32'd0);
    checkOutput("rstSpkEn", {31'd0, SpkEn}, 32'd1);
    checkOutput("asdiZero", {31'd0, Asdi}, 32'd0);
    readReg(ADDR_CTRL, rd);   checkOutput("rstCtrl", {16'd0, rd}, 32'h0002);
    readReg(ADDR_VOLUME, rd); checkOutput("rstVolume", {16'd0, rd}, 32'h0080);
    readReg(ADDR_FREQ, rd);   checkOutput("rstFreq", {16'd0, rd}, 32'h0000);
    readReg(ADDR_STATUS, rd); checkOutput("rstStatus", {16'd0, rd}, 32'h0000);
    readReg(4'd7, rd);        checkOutput("unmapped", {16'd0, rd}, 32'h0000);
    @(negedge Clk);
    Resetn = 1'b1;

    // Mix of two half-scale channels at unity gain
    applyStimulus(ADDR_CTRL, 16'h0002);
    txL = 16'h4000; txR = 16'h4000;
    settle(4);
    countHigh(hi); checkOutput("mixDuty", hi, 768);
    readReg(ADDR_STATUS, statA);
    repeat (2048) @(negedge Clk);
    readReg(ADDR_STATUS, statB);
    checkOutput("frameCnt4", {24'd0, statB[15:8] - statA[15:8]}, 32'd4);
    checkOutput("notMuted", {31'd0, statB[0]}, 32'd0);

    // Left channel, max volume, positive and negative saturation
    applyStimulus(ADDR_CTRL, 16'h0006);
    applyStimulus(ADDR_VOLUME, 16'h00FF);
    readReg(ADDR_VOLUME, rd); checkOutput("volReadback", {16'd0, rd}, 32'h00FF);
    txL = 16'h7FFF;
    settle(4);
    countHigh(hi); checkOutput("satPos", hi, 1023);
    txL = 16'h8000;
    settle(4);
    countHigh(hi); checkOutput("satNeg", hi, 0);

    // Offset-binary input
    applyStimulus(ADDR_CTRL, 16'h0016);
    applyStimulus(ADDR_VOLUME, 16'h0080);
    readReg(ADDR_CTRL, rd); checkOutput("ctrlReadback", {16'd0, rd}, 32'h0016);
    settle(4);
    countHigh(hi); checkOutput("unsMid", hi, 512);
    txL = 16'hC000;
    settle(4);
    countHigh(hi); checkOutput("unsHigh", hi, 768);

    // Idle mute after unchanged periods, then recovery on new audio
    settle(16);
    readReg(ADDR_STATUS, rd); checkOutput("mutedSet", {31'd0, rd[0]}, 32'd1);
    countHigh(hi); checkOutput("mutedOut", hi, 0);
    txL = 16'h4000;
    settle(3);
    readReg(ADDR_STATUS, rd); checkOutput("mutedClear", {31'd0, rd[0]}, 32'd0);
    countHigh(hi); checkOutput("resumeDuty", hi, 256);

    // Off modes
    applyStimulus(ADDR_CTRL, 16'h0014);
    @(negedge Clk);
    checkOutput("mode0SpkEn", {31'd0, SpkEn}, 32'd0);
    countHigh(hi); checkOutput("mode0Out", hi, 0);
    applyStimulus(ADDR_CTRL, 16'h0017);
    @(negedge Clk);
    checkOutput("mode3SpkEn", {31'd0, SpkEn}, 32'd1);
    countHigh(hi); checkOutput("mode3Out", hi, 0);

    // Tone at Freq=4 with quarter loudness, compared cycle by cycle
    applyStimulus(ADDR_VOLUME, 16'h0040);
    applyStimulus(ADDR_FREQ, 16'h0004);
    readReg(ADDR_FREQ, rd); checkOutput("freqReadback", {16'd0, rd}, 32'h0004);
    applyStimulus(ADDR_CTRL, 16'h0015);
    repeat (4) @(negedge Clk);
    errs = 0; hi = 0;
    repeat (3000) begin
      @(negedge Clk);
      if (Out !== mOut) errs++;
      if (mOut) hi++;
    end
    checkOutput("toneModel", errs, 0);
    checkOutput("toneActive", {31'd0, (hi > 0)}, 32'd1);

    // Reset in the middle of a slot while the pin is high
    waited = 0;
    while (!Out && waited < 1000) begin
      @(negedge Clk);
      waited++;
    end
    checkOutput("toneOutHigh", {31'd0, Out}, 32'd1);
    Resetn = 1'b0;
    txL = 16'h2000; txR = 16'h2000;
    #1;
    checkOutput("midRstOut", {31'd0, Out}, 32'd0);
    checkOutput("midRstSpkEn", {31'd0, SpkEn}, 32'd1);
    readReg(ADDR_CTRL, rd);   checkOutput("midRstCtrl", {16'd0, rd}, 32'h0002);
    readReg(ADDR_VOLUME, rd); checkOutput("midRstVolume", {16'd0, rd}, 32'h0080);
    readReg(ADDR_FREQ, rd);   checkOutput("midRstFreq", {16'd0, rd}, 32'h0000);
    readReg(ADDR_STATUS, rd); checkOutput("midRstStatus", {16'd0, rd}, 32'h0000);
    repeat (3) @(negedge Clk);
    Resetn = 1'b1;
    settle(4);
    countHigh(hi); checkOutput("postRstDuty", hi, 640);

    $display("CHECKS %0d ERRORS %0d", checkCount, errCount);
    $finish;
  end

endmodule
